// File: rtl/nf10_axis_replay_master.sv
// AXI4-Stream replay master: a preloaded beat buffer is streamed out on a start
// pulse, repeated a programmable number of times with an optional inter-packet gap.
module nf10_axis_replay_master #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_ADDR_WIDTH         = 6
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic                              load_en,
  input  logic [C_ADDR_WIDTH-1:0]           load_addr,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]    load_tdata,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  load_tstrb,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   load_tuser,
  input  logic                              load_tlast,
  input  logic                              start,
  input  logic [C_ADDR_WIDTH:0]             num_beats,
  input  logic [15:0]                       num_loops,
  input  logic [7:0]                        ifg,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       pkt_count,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam int STRB_W = C_M_AXIS_DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << C_ADDR_WIDTH;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;

  state_t state_q, state_d;

  logic [C_M_AXIS_DATA_WIDTH-1:0]  mem_tdata [DEPTH];
  logic [STRB_W-1:0]               mem_tstrb [DEPTH];
  logic [C_M_AXIS_TUSER_WIDTH-1:0] mem_tuser [DEPTH];
  logic                            mem_tlast [DEPTH];

  logic [C_ADDR_WIDTH-1:0]         addr_q, addr_d, last_addr_q, last_addr_d;
  logic [15:0]                     loop_q, loop_d;
  logic [7:0]                      ifg_q, ifg_d, gap_q, gap_d;
  logic [31:0]                     pkt_q, pkt_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [STRB_W-1:0]               tstrb_q, tstrb_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                            tlast_q, tlast_d;

  logic                            load_wr, at_last, fetch;
  logic [C_ADDR_WIDTH-1:0]         next_addr, start_last, rd_addr, rd_last_addr;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  rd_tdata;
  logic [STRB_W-1:0]               rd_tstrb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] rd_tuser;
  logic                            rd_tlast;

  assign busy       = (state_q == SEND) || (state_q == GAP);
  assign done       = (state_q == FINISH);
  assign load_wr    = load_en && !busy;
  assign at_last    = (addr_q == last_addr_q);
  assign next_addr  = at_last ? '0 : addr_q + ADDR_ONE;
  assign start_last = num_beats[C_ADDR_WIDTH-1:0] - ADDR_ONE;

  // NOTE: the beat buffer is deliberately left out of reset so it survives a replay abort.
  always_ff @(posedge aclk) begin
    if (load_wr) begin
      mem_tdata[load_addr] <= load_tdata;
      mem_tstrb[load_addr] <= load_tstrb;
      mem_tuser[load_addr] <= load_tuser;
      mem_tlast[load_addr] <= load_tlast;
    end
  end

  always_comb begin
    rd_addr      = '0;
    rd_last_addr = (state_q == IDLE) ? start_last : last_addr_q;
    case (state_q)
      SEND:    rd_addr = next_addr;
      GAP:     rd_addr = addr_q;
      default: rd_addr = '0;
    endcase
  end

  // A write landing on the word being fetched this cycle is forwarded, so a
  // load coinciding with start replays the freshly written contents.
  always_comb begin
    rd_tdata = mem_tdata[rd_addr];
    rd_tstrb = mem_tstrb[rd_addr];
    rd_tuser = mem_tuser[rd_addr];
    rd_tlast = mem_tlast[rd_addr];
    if (load_wr && (load_addr == rd_addr)) begin
      rd_tdata = load_tdata;
      rd_tstrb = load_tstrb;
      rd_tuser = load_tuser;
      rd_tlast = load_tlast;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    loop_d      = loop_q;
    ifg_d       = ifg_q;
    gap_d       = gap_q;
    pkt_d       = pkt_q;
    fetch       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pkt_d = '0;
          if (num_beats == '0) begin
            state_d = FINISH;
          end else begin
            state_d     = SEND;
            addr_d      = '0;
            last_addr_d = start_last;
            loop_d      = (num_loops == 16'd0) ? 16'd1 : num_loops;
            ifg_d       = ifg;
            fetch       = 1'b1;
          end
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          addr_d = next_addr;
          if (!tlast_q) begin
            fetch = 1'b1;
          end else begin
            pkt_d = pkt_q + 32'd1;
            if (at_last) loop_d = loop_q - 16'd1;
            if (at_last && (loop_q == 16'd1)) begin
              state_d = FINISH;
            end else if (ifg_q != 8'd0) begin
              state_d = GAP;
              gap_d   = ifg_q;
            end else begin
              fetch = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (gap_q <= 8'd1) begin
          state_d = SEND;
          fetch   = 1'b1;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    tdata_d = tdata_q;
    tstrb_d = tstrb_q;
    tuser_d = tuser_q;
    tlast_d = tlast_q;
    if (fetch) begin
      tdata_d = rd_tdata;
      tstrb_d = rd_tstrb;
      tuser_d = rd_tuser;
      tlast_d = rd_tlast || (rd_addr == rd_last_addr);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      loop_q      <= '0;
      ifg_q       <= '0;
      gap_q       <= '0;
      pkt_q       <= '0;
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      loop_q      <= loop_d;
      ifg_q       <= ifg_d;
      gap_q       <= gap_d;
      pkt_q       <= pkt_d;
      tdata_q     <= tdata_d;
      tstrb_q     <= tstrb_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tlast  = tlast_q && (state_q == SEND);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tuser  = tuser_q;
  assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_nf10_axis_replay_master.sv
// Scoreboard bench for nf10_axis_replay_master: stimulus pushes expected beats,
// a negedge monitor pops and compares them on every handshake.
module tb_nf10_axis_replay_master;

  localparam int DW = 256;
  localparam int SW = 32;
  localparam int UW = 128;
  localparam int AW = 6;

  logic          aclk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_tdata;
  logic [SW-1:0] load_tstrb;
  logic [UW-1:0] load_tuser;
  logic          load_tlast;
  logic          start;
  logic [AW:0]   num_beats;
  logic [15:0]   num_loops;
  logic [7:0]    ifg;
  logic          busy, done;
  logic [31:0]   pkt_count;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;

  typedef struct packed {
    logic [DW-1:0] tdata;
    logic [SW-1:0] tstrb;
    logic [UW-1:0] tuser;
    logic          tlast;
  } beat_t;

  beat_t model [64];
  beat_t exp_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  nf10_axis_replay_master dut (
    .aclk          (aclk),
    .reset         (reset),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_tdata    (load_tdata),
    .load_tstrb    (load_tstrb),
    .load_tuser    (load_tuser),
    .load_tlast    (load_tlast),
    .start         (start),
    .num_beats     (num_beats),
    .num_loops     (num_loops),
    .ifg           (ifg),
    .busy          (busy),
    .done          (done),
    .pkt_count     (pkt_count),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every handshake against the scoreboard and checks that a
  // stalled beat stays frozen until it is accepted.
  beat_t held, got, e;
  logic  hold_pending = 1'b0;
  always @(negedge aclk) begin
    got = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("stall_tvalid", m_axis_tvalid, 1'b1);
        check("stall_tdata", got.tdata, held.tdata);
        check("stall_side", {got.tstrb, got.tuser, got.tlast}, {held.tstrb, held.tuser, held.tlast});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hold_pending = 1'b0;
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_tdata", got.tdata, e.tdata);
          check("beat_side", {got.tstrb, got.tuser, got.tlast}, {e.tstrb, e.tuser, e.tlast});
        end
      end else begin
        hold_pending = m_axis_tvalid;
        held         = got;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic beat_t mk(input int idx, input logic last);
    beat_t b;
    b.tdata = {8{32'hC0DE_0000 + 32'(idx)}};
    b.tstrb = 32'h0F0F_00FF ^ 32'(idx * 7);
    b.tuser = {4{32'hBEEF_0000 + 32'(idx)}};
    b.tlast = last;
    return b;
  endfunction

  task automatic load_beat(input int addr, input int idx, input logic last);
    beat_t b;
    b          = mk(idx, last);
    load_en    = 1'b1;
    load_addr  = 6'(addr);
    load_tdata = b.tdata;
    load_tstrb = b.tstrb;
    load_tuser = b.tuser;
    load_tlast = b.tlast;
    tick();
    load_en      = 1'b0;
    model[addr]  = b;
  endtask

  function automatic void push_replay(input int nb, input int loops);
    beat_t b;
    int nl;
    nl = (loops == 0) ? 1 : loops;
    for (int l = 0; l < nl; l++) begin
      for (int a = 0; a < nb; a++) begin
        b       = model[a];
        b.tlast = b.tlast | (a == nb - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic start_replay(input int nb, input int loops, input int g);
    num_beats = 7'(nb);
    num_loops = 16'(loops);
    ifg       = 8'(g);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Per-cycle expectation: v = beat presented, . = gap, d = done, - = idle.
  // With disturb set, start and load_en are driven in every busy cycle.
  task automatic run_trace(input string pat, input logic disturb, input logic [31:0] exp_pkt);
    byte c;
    for (int i = 0; i < pat.len(); i++) begin
      c = pat[i];
      check("trace_tvalid", m_axis_tvalid, c == "v");
      check("trace_done", done, c == "d");
      check("trace_busy", busy, (c == "v") || (c == "."));
      if (c != "v") check("trace_tlast_idle", m_axis_tlast, 1'b0);
      if (c == "d") check("trace_pkt_count", pkt_count, exp_pkt);
      if (disturb && ((c == "v") || (c == "."))) begin
        start      = 1'b1;
        num_beats  = 7'd1;
        num_loops  = 16'd9;
        ifg        = 8'd0;
        load_en    = 1'b1;
        load_addr  = 6'(i % 5);
        load_tdata = '1;
        load_tstrb = '0;
        load_tuser = '1;
        load_tlast = 1'b1;
      end else begin
        start   = 1'b0;
        load_en = 1'b0;
      end
      tick();
    end
    start   = 1'b0;
    load_en = 1'b0;
  endtask

  initial begin
    beat_t b;
    logic  done_seen;
    reset         = 1'b1;
    load_en       = 1'b0;
    load_addr     = '0;
    load_tdata    = '0;
    load_tstrb    = '0;
    load_tuser    = '0;
    load_tlast    = 1'b0;
    start         = 1'b0;
    num_beats     = '0;
    num_loops     = '0;
    ifg           = '0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_count", pkt_count, 32'd0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    reset = 1'b0;
    tick();

    // Single 4-beat packet, no gap.
    for (int a = 0; a < 4; a++) load_beat(a, a, a == 3);
    push_replay(4, 1);
    start_replay(4, 1, 0);
    run_trace("vvvvd-", 1'b0, 32'd1);
    check("sb_empty_basic", exp_q.size() == 0, 1'b1);

    // Three loops separated by two idle cycles.
    push_replay(4, 3);
    start_replay(4, 3, 2);
    run_trace("vvvv..vvvv..vvvvd-", 1'b0, 32'd3);
    check("sb_empty_loops", exp_q.size() == 0, 1'b1);

    // Random backpressure over 8 beats holding two packets.
    for (int a = 0; a < 8; a++) load_beat(a, 10 + a, (a == 3) || (a == 7));
    push_replay(8, 1);
    start_replay(8, 1, 0);
    done_seen = 1'b0;
    for (int k = 0; k < 400 && !done_seen; k++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      if (done) done_seen = 1'b1;
    end
    check("rand_done_seen", done_seen, 1'b1);
    check("rand_pkt_count", pkt_count, 32'd2);
    m_axis_tready = 1'b1;
    tick();
    check("sb_empty_rand", exp_q.size() == 0, 1'b1);

    // No stored tlast: forced on the final beat of each loop; then an empty replay.
    for (int a = 0; a < 5; a++) load_beat(a, 20 + a, 1'b0);
    push_replay(5, 2);
    start_replay(5, 2, 0);
    run_trace("vvvvvvvvvvd-", 1'b0, 32'd2);
    start_replay(0, 1, 0);
    run_trace("d-", 1'b0, 32'd0);
    check("sb_empty_forced", exp_q.size() == 0, 1'b1);

    // Reset while the third beat is stalled.
    b = model[0];
    exp_q.push_back(b);
    b = model[1];
    b.tlast = 1'b1;
    exp_q.push_back(b);
    start_replay(2, 3, 0);
    tick();
    tick();
    m_axis_tready = 1'b0;
    check("pre_rst_tvalid", m_axis_tvalid, 1'b1);
    check("pre_rst_pkt_count", pkt_count, 32'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pkt_count", pkt_count, 32'd0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_tdata", m_axis_tdata, '0);
    check("sb_empty_rst", exp_q.size() == 0, 1'b1);
    m_axis_tready = 1'b1;
    tick();
    push_replay(5, 1);
    start_replay(5, 1, 0);
    run_trace("vvvvvd-", 1'b0, 32'd1);

    // start and load_en while busy are ignored; buffer is unchanged afterwards.
    push_replay(5, 2);
    start_replay(5, 2, 3);
    run_trace("vvvvv...vvvvvd-", 1'b1, 32'd2);
    push_replay(5, 1);
    start_replay(5, 1, 0);
    run_trace("vvvvvd-", 1'b0, 32'd1);

    // Write and start in the same cycle: replay sees the new word.
    b          = mk(99, 1'b0);
    load_en    = 1'b1;
    load_addr  = 6'd0;
    load_tdata = b.tdata;
    load_tstrb = b.tstrb;
    load_tuser = b.tuser;
    load_tlast = b.tlast;
    model[0]   = b;
    push_replay(1, 1);
    start_replay(1, 1, 0);
    load_en = 1'b0;
    run_trace("vd-", 1'b0, 32'd1);

    check("sb_final_empty", exp_q.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
